// File: rtl/branch_resolution_unit.sv
// Branch resolution for the pipelined LC-3b: checks each branch against the
// prediction it was fetched with, drives the predictor update port and flushes/redirects fetch.
module branch_resolution_unit #(
  parameter int width      = 16,
  parameter int PIPE_DEPTH = 3,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             fetch_valid,
  input  logic [width-1:0] fetch_pc,
  input  logic             pred_taken,
  input  logic [width-1:0] pred_target,
  input  logic             res_valid,
  input  logic [width-1:0] res_pc,
  input  logic [width-1:0] res_ir,
  input  logic             res_taken,
  input  logic [width-1:0] res_target,
  output logic [width-1:0] upd_pc,
  output logic [width-1:0] upd_target,
  output logic [width-1:0] upd_ir,
  output logic             upd_taken,
  output logic             upd_stall,
  output logic             flush,
  output logic             redirect_valid,
  output logic [width-1:0] redirect_pc,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count
);

  // state    | meaning
  // IDLE     | resolutions accepted, metadata shifting
  // REDIRECT | flush/redirect presented; resolve stage is wrong-path
  typedef enum logic {IDLE, REDIRECT} state_t;

  localparam int H = PIPE_DEPTH - 1;

  state_t                  state;
  logic [PIPE_DEPTH-1:0]   meta_valid;
  logic [width-1:0]        meta_pc     [PIPE_DEPTH];
  logic                    meta_taken  [PIPE_DEPTH];
  logic [width-1:0]        meta_target [PIPE_DEPTH];

  logic             head_hit;
  logic             eff_taken;
  logic             true_branch;
  logic             accept;
  logic             mispredict;
  logic [width-1:0] dest_pc;

  always_comb begin
    head_hit    = meta_valid[H] && (meta_pc[H] == res_pc);
    eff_taken   = head_hit && meta_taken[H];
    true_branch = (res_ir[15:12] == 4'h0) && (res_ir[11:9] != 3'b000);
    accept      = res_valid && !stall && (state == IDLE);
    if (true_branch && res_taken)
      mispredict = !eff_taken || (meta_target[H] != res_target);
    else
      mispredict = eff_taken;
    dest_pc = (true_branch && res_taken) ? res_target : res_pc + width'(2);
  end

  // Metadata only carries the pc/prediction fields; entries are qualified by valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_valid <= '0;
    end else if (!stall) begin
      if (state == REDIRECT) meta_valid <= '0;
      else                   meta_valid <= {meta_valid[PIPE_DEPTH-2:0], fetch_valid};
      meta_pc[0]     <= fetch_pc;
      meta_taken[0]  <= pred_taken;
      meta_target[0] <= pred_target;
      for (int i = 1; i < PIPE_DEPTH; i++) begin
        meta_pc[i]     <= meta_pc[i-1];
        meta_taken[i]  <= meta_taken[i-1];
        meta_target[i] <= meta_target[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      flush          <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept && mispredict) begin
            state          <= REDIRECT;
            flush          <= 1'b1;
            redirect_valid <= 1'b1;
            redirect_pc    <= dest_pc;
          end
        end
        REDIRECT: begin
          if (!stall) begin
            state          <= IDLE;
            flush          <= 1'b0;
            redirect_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      upd_pc           <= '0;
      upd_target       <= '0;
      upd_ir           <= '0;
      upd_taken        <= 1'b0;
      upd_stall        <= 1'b1;
      branch_count     <= '0;
      mispredict_count <= '0;
    end else begin
      upd_stall <= !(accept && true_branch);
      if (accept && true_branch) begin
        upd_pc     <= res_pc;
        upd_target <= res_target;
        upd_ir     <= res_ir;
        upd_taken  <= res_taken;
        if (!(&branch_count)) branch_count <= branch_count + CNT_W'(1);
      end
      if (accept && mispredict && !(&mispredict_count))
        mispredict_count <= mispredict_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_resolution_unit.sv
// Randomized and directed bench for branch_resolution_unit against a fetch-history model.
module tb_branch_resolution_unit;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, stall, fetch_valid, pred_taken, res_valid, res_taken;
  logic [15:0] fetch_pc, pred_target, res_pc, res_ir, res_target;

  logic [15:0] upd_pc, upd_target, upd_ir, redirect_pc;
  logic        upd_taken, upd_stall, flush, redirect_valid;
  logic [15:0] branch_count, mispredict_count;

  logic [15:0] s_upd_pc, s_upd_target, s_upd_ir, s_redirect_pc;
  logic        s_upd_taken, s_upd_stall, s_flush, s_redirect_valid;
  logic [3:0]  s_branch_count, s_mispredict_count;

  branch_resolution_unit #(.width(16), .PIPE_DEPTH(3), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .fetch_valid(fetch_valid),
    .fetch_pc(fetch_pc), .pred_taken(pred_taken), .pred_target(pred_target),
    .res_valid(res_valid), .res_pc(res_pc), .res_ir(res_ir), .res_taken(res_taken),
    .res_target(res_target), .upd_pc(upd_pc), .upd_target(upd_target), .upd_ir(upd_ir),
    .upd_taken(upd_taken), .upd_stall(upd_stall), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .branch_count(branch_count), .mispredict_count(mispredict_count));

  branch_resolution_unit #(.width(16), .PIPE_DEPTH(3), .CNT_W(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .stall(stall), .fetch_valid(fetch_valid),
    .fetch_pc(fetch_pc), .pred_taken(pred_taken), .pred_target(pred_target),
    .res_valid(res_valid), .res_pc(res_pc), .res_ir(res_ir), .res_taken(res_taken),
    .res_target(res_target), .upd_pc(s_upd_pc), .upd_target(s_upd_target), .upd_ir(s_upd_ir),
    .upd_taken(s_upd_taken), .upd_stall(s_upd_stall), .flush(s_flush),
    .redirect_valid(s_redirect_valid), .redirect_pc(s_redirect_pc),
    .branch_count(s_branch_count), .mispredict_count(s_mispredict_count));

  int total = 0;
  int bad   = 0;

  // Model: every non-stalled cycle appends its fetch to a history; the head seen by the
  // resolve stage is the fetch three non-stalled cycles back, unless a clear came later.
  typedef struct { bit v; logic [15:0] pc; bit pt; logic [15:0] tg; } fe_t;
  fe_t hq[$];
  int  clr = -1;
  bit          m_redir, m_flush, m_utk, m_ustall;
  logic [15:0] m_rpc, m_upc, m_utg, m_uir;
  int          m_bc, m_mc;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push_fetch();
    fe_t e;
    e.v = fetch_valid; e.pc = fetch_pc; e.pt = pred_taken; e.tg = pred_target;
    hq.push_back(e);
  endtask

  task automatic model_step();
    bit tb_br, pt, mis;
    logic [15:0] ptg, dest;
    if (!rst_n) begin
      m_redir = 0; m_flush = 0; m_rpc = 0; m_upc = 0; m_utg = 0; m_uir = 0;
      m_utk = 0; m_ustall = 1; m_bc = 0; m_mc = 0;
      push_fetch();
      clr = hq.size() - 1;
    end else if (m_redir) begin
      m_ustall = 1;
      if (!stall) begin
        m_redir = 0; m_flush = 0;
        push_fetch();
        clr = hq.size() - 1;
      end
    end else begin
      m_ustall = 1;
      if (res_valid && !stall) begin
        pt = 0; ptg = 0;
        if (hq.size() >= 3) begin
          if (hq[hq.size()-3].v && (hq.size() - 3) > clr && hq[hq.size()-3].pc == res_pc) begin
            pt = hq[hq.size()-3].pt; ptg = hq[hq.size()-3].tg;
          end
        end
        tb_br = (res_ir[15:12] == 4'h0) && (res_ir[11:9] != 3'b000);
        if (tb_br) begin
          m_bc++; m_upc = res_pc; m_utg = res_target; m_uir = res_ir; m_utk = res_taken;
          m_ustall = 0;
        end
        if (tb_br && res_taken) begin
          mis = !pt || (ptg != res_target); dest = res_target;
        end else begin
          mis = pt; dest = res_pc + 16'd2;
        end
        if (mis) begin
          m_mc++; m_redir = 1; m_flush = 1; m_rpc = dest;
        end
      end
      if (!stall) push_fetch();
    end
  endtask

  task automatic check_all();
    chk("flush", flush, m_flush);
    chk("redirect_valid", redirect_valid, m_flush);
    chk("redirect_pc", redirect_pc, m_rpc);
    chk("upd_stall", upd_stall, m_ustall);
    chk("upd_pc", upd_pc, m_upc);
    chk("upd_target", upd_target, m_utg);
    chk("upd_ir", upd_ir, m_uir);
    chk("upd_taken", upd_taken, m_utk);
    chk("branch_count", branch_count, (m_bc > 65535) ? 65535 : m_bc);
    chk("mispredict_count", mispredict_count, (m_mc > 65535) ? 65535 : m_mc);
    chk("sat_flush", s_flush, m_flush);
    chk("sat_branch_count", s_branch_count, (m_bc > 15) ? 15 : m_bc);
    chk("sat_mispredict_count", s_mispredict_count, (m_mc > 15) ? 15 : m_mc);
  endtask

  task automatic cyc();
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic idle_in();
    stall = 0; fetch_valid = 0; pred_taken = 0; res_valid = 0; res_taken = 0;
  endtask

  task automatic fetch(input logic [15:0] pc, input bit pt, input logic [15:0] tg);
    fetch_valid = 1; fetch_pc = pc; pred_taken = pt; pred_target = tg;
  endtask

  task automatic resolve(input logic [15:0] pc, input logic [15:0] ir, input bit tk,
                         input logic [15:0] tg);
    res_valid = 1; res_pc = pc; res_ir = ir; res_taken = tk; res_target = tg;
  endtask

  initial begin
    rst_n = 0; idle_in();
    fetch_pc = 0; pred_target = 0; res_pc = 0; res_ir = 0; res_target = 0;
    @(negedge clk);
    cyc(); cyc();
    chk("rst_flush", flush, 0);
    chk("rst_upd_stall", upd_stall, 1);
    chk("rst_redirect_pc", redirect_pc, 0);

    // Correct taken prediction
    rst_n = 1; fetch(16'h3000, 1, 16'h3010); cyc();
    idle_in(); cyc(); cyc();
    resolve(16'h3000, 16'h0E08, 1, 16'h3010); cyc();
    chk("t1_flush", flush, 0);
    chk("t1_upd_stall", upd_stall, 0);
    chk("t1_upd_pc", upd_pc, 16'h3000);
    chk("t1_upd_taken", upd_taken, 1);
    chk("t1_bc", branch_count, 1);
    chk("t1_mc", mispredict_count, 0);

    // Missed taken
    resolve(16'h3004, 16'h0402, 1, 16'h300A); cyc();
    chk("t2_flush", flush, 1);
    chk("t2_redirect_pc", redirect_pc, 16'h300A);
    chk("t2_mc", mispredict_count, 1);
    idle_in(); cyc();
    chk("t2_flush_end", flush, 0);

    // False taken
    fetch(16'h3006, 1, 16'h3020); cyc();
    idle_in(); cyc(); cyc();
    resolve(16'h3006, 16'h0802, 0, 16'h3020); cyc();
    chk("t3_redirect_pc", redirect_pc, 16'h3008);
    chk("t3_upd_taken", upd_taken, 0);
    chk("t3_bc", branch_count, 3);
    idle_in(); cyc();

    // Aliased prediction on ADD at 0xFFFE, then stall while in REDIRECT
    fetch(16'hFFFE, 1, 16'h1234); cyc();
    idle_in(); cyc(); cyc();
    resolve(16'hFFFE, 16'h1000, 0, 16'h0000); cyc();
    chk("t4_redirect_pc", redirect_pc, 16'h0000);
    chk("t4_upd_stall", upd_stall, 1);
    chk("t4_bc", branch_count, 3);
    resolve(16'h3000, 16'h0E08, 1, 16'h5555); stall = 1; cyc();
    chk("t5_flush_s1", flush, 1);
    cyc();
    chk("t5_flush_s2", flush, 1);
    chk("t5_redirect_pc", redirect_pc, 16'h0000);
    stall = 0; fetch(16'h3000, 1, 16'h3010); cyc();
    chk("t5_flush_end", flush, 0);
    chk("t5_bc", branch_count, 3);
    chk("t5_upd_stall", upd_stall, 1);
    // The fetch issued during REDIRECT must not supply a prediction
    idle_in(); cyc(); cyc();
    resolve(16'h3000, 16'h0E08, 1, 16'h3010); cyc();
    chk("t5_flushed_fetch", flush, 1);
    chk("t5_redirect_pc2", redirect_pc, 16'h3010);

    // Reset mid-REDIRECT
    idle_in(); rst_n = 0; cyc();
    chk("t6_flush", flush, 0);
    chk("t6_bc", branch_count, 0);
    chk("t6_mc", mispredict_count, 0);
    chk("t6_upd_stall", upd_stall, 1);
    rst_n = 1;

    // Saturation of the 4-bit counters
    for (int i = 0; i < 17; i++) begin
      resolve(16'h3004, 16'h0402, 1, 16'h300A); cyc();
      idle_in(); cyc();
    end
    chk("sat_mc4", s_mispredict_count, 15);
    chk("sat_bc4", s_branch_count, 15);
    chk("sat_mc16", mispredict_count, 17);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rst_n       = ($urandom_range(255) != 0);
      stall       = ($urandom_range(4) == 0);
      fetch_valid = $urandom_range(1);
      fetch_pc    = 16'h3000 + 16'($urandom_range(15) * 2);
      pred_taken  = $urandom_range(1);
      pred_target = 16'h3000 + 16'($urandom_range(7) * 4);
      res_valid   = $urandom_range(1);
      res_taken   = $urandom_range(1);
      if (hq.size() >= 3 && $urandom_range(9) < 7) res_pc = hq[hq.size()-3].pc;
      else if ($urandom_range(7) == 0)             res_pc = 16'hFFFE;
      else res_pc = 16'h3000 + 16'($urandom_range(15) * 2);
      if (hq.size() >= 3 && $urandom_range(1) == 1) res_target = hq[hq.size()-3].tg;
      else res_target = 16'h3000 + 16'($urandom_range(7) * 4);
      case ($urandom_range(3))
        0, 1:    res_ir = {4'h0, 3'($urandom_range(7)), 9'($urandom)};
        2:       res_ir = {4'h0, 3'b000, 9'($urandom)};
        default: res_ir = 16'($urandom);
      endcase
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/branch_resolution_unit.md
# branch_resolution_unit

Resolves conditional branches for the pipelined LC-3b and closes the loop with the branch predictor. It carries each fetched instruction's prediction (taken flag and target) down the pipeline, compares it with the actual outcome at the resolve stage, and drives the predictor update port: source PC, target, IR, taken, and write-enable. On a misprediction it issues a one-cycle flush/redirect to fetch. It also keeps saturating branch and mispredict counters.

## Interface
- `width`, 16: PC/IR width.
- `PIPE_DEPTH`, 3: cycles (non-stalled) from fetch to resolve stage; depth of metadata shift register.
- `CNT_W`, 16: performance counter width.
- `clk`  in  1  clock; all state changes on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `stall`  in  1  pipeline stall; freezes metadata, FSM holds, no resolution accepted.
- `fetch_valid`  in  1  fetch stage issued an instruction this cycle.
- `fetch_pc`  in  width  PC of fetched instruction.
- `pred_taken`  in  1  predictor `take_branch` for `fetch_pc`.
- `pred_target`  in  width  predictor target for `fetch_pc`.
- `res_valid`  in  1  valid instruction in resolve stage.
- `res_pc`, `res_ir`  in  width  PC / IR of resolving instruction.
- `res_taken`  in  1  actual nzp condition met.
- `res_target`  in  width  computed branch target.
- `upd_pc`, `upd_target`, `upd_ir`  out  width  to predictor source_pc / target_pc / source_ir.
- `upd_taken`  out  1  to predictor if_taken.
- `upd_stall`  out  1  to predictor stall; 0 only in the cycle an update is presented.
- `flush`  out  1  squash all stages younger than resolve.
- `redirect_valid`  out  1  fetch must load `redirect_pc`.
- `redirect_pc`  out  width  corrected fetch PC.
- `branch_count`, `mispredict_count`  out  CNT_W  saturating counters.

## Operation
- Metadata shift register, PIPE_DEPTH entries of {valid, pc, pred_taken, pred_target}.
  - Entry 0 loads {fetch_valid, fetch_pc, pred_taken, pred_target}.
  - Shifts only when !stall.
  - Entry PIPE_DEPTH-1 (head) aligns with the resolve stage.
- True branch: `res_ir[15:12]==0 && res_ir[11:9]!=0`. BR with nzp=000 is a non-branch.
- Effective prediction: head.pred_taken and head.pred_target if head.valid && head.pc==res_pc; otherwise not-taken.
- Resolution is accepted when res_valid && !stall && state==IDLE.
- Mispredict, evaluated on accepted resolution:
  - true branch, res_taken, and (not predicted taken, or pred_target!=res_target) → redirect to res_target.
  - true branch, !res_taken, predicted taken → redirect to res_pc+2.
  - non-branch, predicted taken → redirect to res_pc+2.
  - res_pc+2 is computed modulo 2^width; 16'hFFFE+2 = 16'h0000.
- FSM, two states:
  - IDLE: on an accepted mispredict, register redirect_pc and go to REDIRECT.
  - REDIRECT: flush=1, redirect_valid=1. If stall, stay and hold redirect_pc. Else clear all metadata valid bits (this cycle's fetch_valid is ignored) and return to IDLE.
  - In REDIRECT, res_* inputs are wrong-path: no update, no counting.
- Update: on an accepted true branch, register upd_pc=res_pc, upd_target=res_target, upd_ir=res_ir, upd_taken=res_taken. Next cycle upd_stall=0 for exactly one cycle; otherwise upd_stall=1. Update data holds its last value.
- Counters:
  - branch_count +1 per accepted true branch.
  - mispredict_count +1 per accepted mispredict.
  - Both saturate at all-ones.
- Reset (rst_n=0 at an edge, at any time including mid-REDIRECT):
  - FSM→IDLE; metadata valid cleared; counters 0.
  - flush=0, redirect_valid=0, redirect_pc=0, upd_*=0, upd_stall=1.

## Timing
- Resolution in cycle N → flush/redirect_valid/update asserted in cycle N+1 (registered outputs, no combinational in→out paths).
- Redirected fetch is issued in cycle N+2.
- flush/redirect_valid last exactly one non-stalled cycle; they stretch across stall cycles.
- Update and redirect for the same branch appear in the same cycle.
- A flushed fetch (entered during REDIRECT) never reaches the head valid.
- Stall in cycle N blocks acceptance; the resolve stage is re-evaluated at the first non-stalled cycle.

## Test plan
- Correct taken prediction: fetch_pc=0x3000 with pred_taken=1, pred_target=0x3010; 3 cycles later res_ir=0x0E08 (BRnzp), res_taken=1, res_target=0x3010 → no flush; next cycle upd_stall=0, upd_pc=0x3000, upd_taken=1; branch_count=1, mispredict_count=0.
- Missed taken: no prediction; res_pc=0x3004, res_ir=0x0402 (BRz), res_taken=1, res_target=0x300A → next cycle flush=1, redirect_pc=0x300A, mispredict_count=1; all metadata valid=0 afterwards.
- False taken: pred_taken=1 for 0x3006; res_ir=0x0802 (BRn), res_taken=0 → redirect_pc=0x3008, upd_taken=0.
- Aliasing on a non-branch: pred_taken=1 for ADD at 0xFFFE → redirect_pc=0x0000, upd_stall stays 1, branch_count unchanged.
- Stall during REDIRECT: stall=1 for 2 cycles → flush/redirect_valid held 3 cycles, redirect_pc stable; res_* during REDIRECT ignored.
- Reset mid-REDIRECT and saturation:
  - rst_n=0 mid-REDIRECT → next cycle flush=0, counters 0, upd_stall=1.
  - With CNT_W=4, 16 mispredicts → mispredict_count=15.
